// File: rtl/sram_ctrl_pkg.sv
// Shared definitions for the SRAM arbitration controller: default bus
// widths, FSM state encoding and requester port indices.
package sram_ctrl_pkg;

    localparam int DEF_ADDR_W = 19;
    localparam int DEF_DATA_W = 8;

    // Access sequencing states; every access walks IDLE->SETUP->STROBE->HOLD.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        STROBE = 2'd2,
        HOLD   = 2'd3
    } state_t;

    localparam logic PORT0 = 1'b0;
    localparam logic PORT1 = 1'b1;

endpackage

// File: rtl/sram_rr_arbiter.sv
// Two-way round-robin arbiter. When both ports request, the port that was
// not granted last wins; the last-grant pointer moves only on a grant.
module sram_rr_arbiter
    import sram_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       grant_en,
    output logic [1:0] grant
);

    logic last;

    // Grant selection; a single requester always wins, ties go to the other port.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        grant = 2'b00;
        if (grant_en) begin
            unique case (req)
                2'b01:   grant = 2'b01;
                2'b10:   grant = 2'b10;
                2'b11:   grant = (last == PORT0) ? 2'b10 : 2'b01;
                default: grant = 2'b00;
            endcase
        end
    end

    // Last-grant pointer; starts at PORT1 so port 0 wins the first tie.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
        if (reset) begin
            last <= PORT1;
        end else if (grant != 2'b00) begin
            last <= grant[1] ? PORT1 : PORT0;
        end
    end

endmodule

// File: rtl/sram_arb_controller.sv
// Timed two-requester controller for a 512K x 8 asynchronous SRAM.
// Each access runs IDLE -> SETUP -> STROBE (WAIT_CYCLES) -> HOLD, with
// ack pulsed in HOLD. Optional macro ACCESS_STATS_EN adds rd_count and
// wr_count outputs counting completed reads and writes.
module sram_arb_controller
    import sram_ctrl_pkg::*;
#(
    parameter int WAIT_CYCLES = 2,
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int DATA_W      = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0,
    input  logic              rw0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] wdata0,
    output logic              ack0,
    input  logic              req1,
    input  logic              rw1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata1,
    output logic              ack1,
    output logic [DATA_W-1:0] rdata,
    output logic              busy,
    output logic [ADDR_W-1:0] ad,
    output logic              we_n,
    output logic              oe_n,
    output logic              ce_a_n,
`ifdef ACCESS_STATS_EN
    output logic [15:0]       rd_count,
    output logic [15:0]       wr_count,
`endif
    inout  wire  [DATA_W-1:0] dio_a
);

    localparam int CNT_W = 4;

    state_t            state;
    state_t            state_nxt;
    logic [CNT_W-1:0]  cnt;
    logic [1:0]        grant;
    logic              lat_port;
    logic              lat_rw;
    logic [ADDR_W-1:0] lat_addr;
    logic [DATA_W-1:0] lat_wdata;
    logic              drive_en;

    sram_rr_arbiter u_arb (
        .clk      (clk),
        .reset    (reset),
        .req      ({req1, req0}),
        .grant_en (state == IDLE),
        .grant    (grant)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; STROBE exits when the down-counter reaches zero.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (grant != 2'b00) state_nxt = SETUP;
            SETUP:   state_nxt = STROBE;
            STROBE:  if (cnt == '0) state_nxt = HOLD;
            HOLD:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Request latch, strobe counter and read capture.
    always_ff @(posedge clk) begin
        // NOTE: only a handful of control/data flops here, so all of them are reset; no memory arrays to worry about.
        if (reset) begin
            lat_port  <= PORT0;
            lat_rw    <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            cnt       <= '0;
            rdata     <= '0;
        end else begin
            if (state == IDLE && grant != 2'b00) begin
                lat_port  <= grant[1] ? PORT1 : PORT0;
                lat_rw    <= grant[1] ? rw1 : rw0;
                lat_addr  <= grant[1] ? addr1 : addr0;
                lat_wdata <= grant[1] ? wdata1 : wdata0;
            end
            if (state == SETUP) begin
                cnt <= CNT_W'(WAIT_CYCLES - 1);
            end else if (state == STROBE && cnt != '0) begin
                cnt <= cnt - 1'b1;
            end
            if (state == STROBE && cnt == '0 && lat_rw) begin
                rdata <= dio_a;
            end
        end
    end

    // SRAM pin and handshake decode from the current state.
    always_comb begin
        we_n     = 1'b1;
        oe_n     = 1'b1;
        ce_a_n   = 1'b1;
        ack0     = 1'b0;
        ack1     = 1'b0;
        drive_en = 1'b0;
        if (state != IDLE) begin
            ce_a_n   = 1'b0;
            // Write data is driven from SETUP through HOLD for setup/hold margin.
            drive_en = !lat_rw;
        end
        if (state == STROBE) begin
            oe_n = !lat_rw;
            we_n = lat_rw;
        end
        if (state == HOLD) begin
            ack0 = (lat_port == PORT0);
            ack1 = (lat_port == PORT1);
        end
    end

    assign busy  = (state != IDLE);
    assign ad    = lat_addr;
    assign dio_a = drive_en ? lat_wdata : {DATA_W{1'bz}};

`ifdef ACCESS_STATS_EN
    // Completed-access counters, bumped once per HOLD cycle, wrapping naturally.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_count <= '0;
            wr_count <= '0;
        end else if (state == HOLD) begin
            if (lat_rw) rd_count <= rd_count + 16'd1;
            else        wr_count <= wr_count + 16'd1;
        end
    end
`endif

endmodule
